// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder for the 1101 Moore sequence detector.
// A one-word holding buffer in front of the shift register lets back-to-back
// words stream with no idle bit between them. ser_out idles at 0 so the
// downstream detector is walked back toward its start state between words.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SHIFT    = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [0:0]       state_r;
  logic [WIDTH-1:0] buf_r;
  logic             buf_full_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             word_done_r;

  logic [0:0]       state_nxt_s;
  logic [WIDTH-1:0] buf_nxt_s;
  logic             buf_full_nxt_s;
  logic [WIDTH-1:0] shreg_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             word_done_nxt_s;
  logic             accept_s;
  logic             load_s;
  logic [WIDTH-1:0] shifted_s;
  logic             out_bit_s;

  // The buffer can take a word only while empty; ready never looks at data_valid.
  assign accept_s = data_valid & ~buf_full_r;

  // Shift one place toward the output end with zero fill, and pick the output bit.
  always_comb begin
    shifted_s = {WIDTH{1'b0}};
    out_bit_s = 1'b0;
    if (MSB_FIRST) begin
      shifted_s = {shreg_r[WIDTH-2:0], 1'b0};
      out_bit_s = shreg_r[WIDTH-1];
    end else begin
      shifted_s = {1'b0, shreg_r[WIDTH-1:1]};
      out_bit_s = shreg_r[0];
    end
  end

  // Next-state decode for the IDLE/SHIFT machine, shifter, counter and buffer.
  always_comb begin
    state_nxt_s     = state_r;
    shreg_nxt_s     = shreg_r;
    cnt_nxt_s       = cnt_r;
    load_s          = 1'b0;
    word_done_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (buf_full_r) begin
          load_s      = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_ZERO) begin
          if (buf_full_r) begin
            load_s      = 1'b1;
            state_nxt_s = SHIFT;
          end else begin
            // Shifting out the final bit leaves the register all zero.
            shreg_nxt_s = shifted_s;
            state_nxt_s = IDLE;
          end
        end else begin
          shreg_nxt_s     = shifted_s;
          cnt_nxt_s       = cnt_r - CNT_ONE;
          // The next cycle shows the last bit of this word.
          word_done_nxt_s = (cnt_r == CNT_ONE);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        shreg_nxt_s = {WIDTH{1'b0}};
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    if (load_s) begin
      shreg_nxt_s = buf_r;
      cnt_nxt_s   = CNT_LAST;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // Holding buffer update; a new accept takes priority over emptying into the shifter.
  always_comb begin
    buf_nxt_s      = buf_r;
    buf_full_nxt_s = buf_full_r;
    if (accept_s) begin
      buf_nxt_s      = data_in;
      buf_full_nxt_s = 1'b1;
    end else if (load_s) begin
      buf_full_nxt_s = 1'b0;
    end else begin
      buf_full_nxt_s = buf_full_r;
    end
  end

  // State registers; reset discards both the buffered and the shifting word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      buf_r       <= {WIDTH{1'b0}};
      buf_full_r  <= 1'b0;
      shreg_r     <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      word_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      buf_r       <= buf_nxt_s;
      buf_full_r  <= buf_full_nxt_s;
      shreg_r     <= shreg_nxt_s;
      cnt_r       <= cnt_nxt_s;
      word_done_r <= word_done_nxt_s;
    end
  end

  assign data_ready = ~buf_full_r;
  assign ser_valid  = (state_r == SHIFT);
  assign ser_out    = (state_r == SHIFT) & out_bit_s;
  assign word_done  = word_done_r;
  assign busy       = (state_r == SHIFT) | buf_full_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, a
// reference 1101 Moore detector on the MSB-first serial output.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in, data_in2;
  logic       data_valid, data_valid2;
  logic       data_ready, ser_out, ser_valid, word_done, busy;
  logic       data_ready2, ser_out2, ser_valid2, word_done2, busy2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] words [0:2];
  logic       det_log [0:31];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .word_done(word_done), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in2), .data_valid(data_valid2),
    .data_ready(data_ready2), .ser_out(ser_out2), .ser_valid(ser_valid2),
    .word_done(word_done2), .busy(busy2)
  );

  // Reference 1101 Moore detector fed by the MSB-first serial output.
  logic [2:0] det_state_r;
  logic       det_out;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) det_state_r <= 3'd0;
    else begin
      case (det_state_r)
        3'd0:    det_state_r <= ser_out ? 3'd1 : 3'd0;
        3'd1:    det_state_r <= ser_out ? 3'd2 : 3'd0;
        3'd2:    det_state_r <= ser_out ? 3'd2 : 3'd3;
        3'd3:    det_state_r <= ser_out ? 3'd4 : 3'd0;
        3'd4:    det_state_r <= ser_out ? 3'd2 : 3'd0;
        default: det_state_r <= 3'd0;
      endcase
    end
  end
  assign det_out = (det_state_r == 3'd4);

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream nw words from words[] with data_valid held high; edge e=0 is the first accept.
  task automatic burst(input int nw, input string tag);
    int   idx;
    int   total;
    logic acc;
    logic exp_v;
    logic exp_bit;
    logic exp_rdy;
    logic exp_done;
    idx        = 0;
    total      = 8 * nw;
    data_in    = words[0];
    data_valid = 1'b1;
    for (int e = 0; e <= total + 1; e++) begin
      acc = data_valid & data_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < nw) data_in = words[idx];
        else begin
          data_valid = 1'b0;
          data_in    = 8'h00;
        end
      end
      exp_v    = (e >= 1) && (e <= total);
      exp_bit  = exp_v ? words[(e - 1) / 8][7 - ((e - 1) % 8)] : 1'b0;
      exp_rdy  = ((e % 8) == 1) || (e > 8 * (nw - 1));
      exp_done = (e >= 8) && ((e % 8) == 0) && (e <= total);
      chk($sformatf("%s_valid_e%0d", tag, e), ser_valid, exp_v);
      chk($sformatf("%s_out_e%0d", tag, e), ser_out, exp_bit);
      chk($sformatf("%s_ready_e%0d", tag, e), data_ready, exp_rdy);
      chk($sformatf("%s_done_e%0d", tag, e), word_done, exp_done);
      chk($sformatf("%s_busy_e%0d", tag, e), busy, (e <= total));
      if (e < 32) det_log[e] = det_out;
    end
  endtask

  initial begin
    logic [7:0] lsb_word;
    int         det_cnt;
    reset       = 1'b0;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    data_in2    = 8'h00;
    data_valid2 = 1'b0;
    for (int i = 0; i < 32; i++) det_log[i] = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_word_done", word_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", data_ready, 1'b1);
    chk("rst_lsb_ready", data_ready2, 1'b1);
    reset = 1'b1;
    step(); step();

    // Single word D0, MSB first
    words[0] = 8'hD0;
    burst(1, "single");
    step();

    // Back-to-back DD then 0D
    words[0] = 8'hDD; words[1] = 8'h0D;
    burst(2, "b2b");
    step();

    // LSB-first instance with 0B: serial order 1,1,0,1,0,0,0,0
    lsb_word    = 8'h0B;
    data_in2    = lsb_word;
    data_valid2 = 1'b1;
    step();
    data_valid2 = 1'b0;
    chk("lsb_e0_valid", ser_valid2, 1'b0);
    chk("lsb_e0_ready", data_ready2, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("lsb_valid_e%0d", e), ser_valid2, 1'b1);
      chk($sformatf("lsb_out_e%0d", e), ser_out2, lsb_word[e - 1]);
      chk($sformatf("lsb_done_e%0d", e), word_done2, (e == 8));
    end
    step();
    chk("lsb_idle_valid", ser_valid2, 1'b0);
    chk("lsb_idle_busy", busy2, 1'b0);
    step();

    // Burst of three words
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF1;
    burst(3, "burst3");
    step();

    // Reset after 3 bits of FF with a second word buffered
    data_in    = 8'hFF;
    data_valid = 1'b1;
    step();                 // edge 0: accept FF
    data_in = 8'hA5;
    step();                 // edge 1: load FF, first bit
    step();                 // edge 2: accept A5
    data_valid = 1'b0;
    step();                 // edge 3: third bit
    chk("mid_valid_before", ser_valid, 1'b1);
    chk("mid_busy_before", busy, 1'b1);
    chk("mid_ready_before", data_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid_async", ser_valid, 1'b0);
    chk("mid_out_async", ser_out, 1'b0);
    chk("mid_busy_async", busy, 1'b0);
    chk("mid_ready_async", data_ready, 1'b1);
    chk("mid_done_async", word_done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_residual_valid_%0d", i), ser_valid, 1'b0);
      chk($sformatf("mid_residual_busy_%0d", i), busy, 1'b0);
    end
    words[0] = 8'h9C;
    burst(1, "after_rst");
    step(); step(); step();

    // Chained with the 1101 detector, stream DD
    words[0] = 8'hDD;
    burst(1, "det");
    chk("det_pulse_e5", det_log[5], 1'b1);
    chk("det_pulse_e9", det_log[9], 1'b1);
    det_cnt = 0;
    for (int e = 0; e <= 9; e++) det_cnt += int'(det_log[e]);
    chk_int("det_pulse_count", det_cnt, 2);
    det_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      det_cnt += int'(det_out);
    end
    chk_int("det_idle_pulses", det_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
